// File: rtl/pci_bus_resolver.sv
// Stand-in for tristate PCI nets: resolves per-agent drives into one bus, models pullups and
// keepers, and flags contention, s/t/s, turnaround and parity violations.
module pci_bus_resolver #(
  parameter int unsigned NUM_AGENTS = 2,
  parameter int unsigned AD_WIDTH   = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_AGENTS*AD_WIDTH-1:0] ad_o,
  input  logic [NUM_AGENTS-1:0]          ad_oe,
  input  logic [NUM_AGENTS*AD_WIDTH/8-1:0] cbe_o,
  input  logic [NUM_AGENTS-1:0]          cbe_oe,
  input  logic [NUM_AGENTS-1:0]          par_o,
  input  logic [NUM_AGENTS-1:0]          par_oe,
  input  logic [NUM_AGENTS*6-1:0]        ctl_o,
  input  logic [NUM_AGENTS*6-1:0]        ctl_oe,
  input  logic                           clr_err,
  output logic [AD_WIDTH-1:0]            ad_bus,
  output logic [AD_WIDTH/8-1:0]          cbe_bus,
  output logic                           par_bus,
  output logic [5:0]                     ctl_bus,
  output logic                           ad_float,
  output logic [3:0]                     contention_err,
  output logic [5:0]                     sts_err,
  output logic                           turnaround_err,
  output logic                           parity_err,
  output logic [CNT_WIDTH-1:0]           contention_count
);

  localparam int unsigned CbeW = AD_WIDTH / 8;
  localparam int unsigned IdxW = (NUM_AGENTS > 2) ? $clog2(NUM_AGENTS) : 1;

  // True when two or more bits of the enable vector are set.
  function automatic logic multi_drv(input logic [NUM_AGENTS-1:0] oe);
    return |(oe & (oe - {{(NUM_AGENTS-1){1'b0}}, 1'b1}));
  endfunction

  logic [AD_WIDTH-1:0]   ad_and, ad_keep_q;
  logic [CbeW-1:0]       cbe_and, cbe_keep_q;
  logic                  par_and, par_keep_q;
  logic [5:0]            ctl_and, ctl_multi, sts_new;
  logic [NUM_AGENTS-1:0] ctl_oe_t [6];
  logic [IdxW-1:0]       ad_idx, owner_q;
  logic                  owner_vld_q, exp_par_q, exp_vld_q;
  logic                  ad_one, ad_multi, cbe_one, cbe_multi, par_one, par_multi;
  logic                  ta_new, par_new, any_cont;
  logic [3:0]            cont_new, cont_q;
  logic [5:0]            sts_q;
  logic                  ta_q, perr_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [NUM_AGENTS*6-1:0] prev_oe_q, prev_o_q, sts_viol;

  // AND of enabled drivers; with no drivers the all-ones start value doubles as the pullup.
  always_comb begin
    ad_and  = '1;
    cbe_and = '1;
    par_and = 1'b1;
    ctl_and = '1;
    ad_idx  = '0;
    sts_new = '0;
    for (int b = 0; b < 6; b++) ctl_oe_t[b] = '0;
    for (int i = 0; i < int'(NUM_AGENTS); i++) begin
      if (ad_oe[i]) begin
        ad_and &= ad_o[i*AD_WIDTH +: AD_WIDTH];
        ad_idx  = IdxW'(i);
      end
      if (cbe_oe[i]) cbe_and &= cbe_o[i*CbeW +: CbeW];
      if (par_oe[i]) par_and &= par_o[i];
      for (int b = 0; b < 6; b++) begin
        ctl_oe_t[b][i] = ctl_oe[i*6+b];
        if (ctl_oe[i*6+b]) ctl_and[b] &= ctl_o[i*6+b];
        sts_new[b] |= sts_viol[i*6+b];
      end
    end
    for (int b = 0; b < 6; b++) ctl_multi[b] = multi_drv(ctl_oe_t[b]);
  end

  assign ad_multi  = multi_drv(ad_oe);
  assign cbe_multi = multi_drv(cbe_oe);
  assign par_multi = multi_drv(par_oe);
  assign ad_one    = (|ad_oe) & ~ad_multi;
  assign cbe_one   = (|cbe_oe) & ~cbe_multi;
  assign par_one   = (|par_oe) & ~par_multi;

  assign ad_bus   = (|ad_oe) ? ad_and : ad_keep_q;
  assign cbe_bus  = (|cbe_oe) ? cbe_and : cbe_keep_q;
  assign par_bus  = (|par_oe) ? par_and : par_keep_q;
  assign ctl_bus  = ctl_and;
  assign ad_float = ~|ad_oe;

  // Released while last driven low, without the one-cycle drive-high.
  assign sts_viol = prev_oe_q & ~prev_o_q & ~ctl_oe;
  assign cont_new = {|ctl_multi, par_multi, cbe_multi, ad_multi};
  assign any_cont = |cont_new;
  assign ta_new   = owner_vld_q & ad_one & (ad_idx != owner_q);
  assign par_new  = exp_vld_q & par_one & (par_bus != exp_par_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      ad_keep_q   <= '0;
      cbe_keep_q  <= '0;
      par_keep_q  <= 1'b0;
      prev_oe_q   <= '0;
      prev_o_q    <= '0;
      owner_q     <= '0;
      owner_vld_q <= 1'b0;
      exp_par_q   <= 1'b0;
      exp_vld_q   <= 1'b0;
      cont_q      <= '0;
      sts_q       <= '0;
      ta_q        <= 1'b0;
      perr_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      if (ad_one) ad_keep_q <= ad_bus;
      if (cbe_one) cbe_keep_q <= cbe_bus;
      if (par_one) par_keep_q <= par_bus;
      prev_oe_q <= ctl_oe;
      prev_o_q  <= ctl_o;
      if (ad_one) begin
        owner_q     <= ad_idx;
        owner_vld_q <= 1'b1;
      end else if (!(|ad_oe)) begin
        owner_vld_q <= 1'b0;
      end
      if (ad_one) exp_par_q <= ^{ad_bus[31:0], cbe_bus[3:0]};
      exp_vld_q <= ad_one;
      if (clr_err) begin
        cont_q <= '0;
        sts_q  <= '0;
        ta_q   <= 1'b0;
        perr_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        cont_q <= cont_q | cont_new;
        sts_q  <= sts_q | sts_new;
        ta_q   <= ta_q | ta_new;
        perr_q <= perr_q | par_new;
        if (any_cont && !(&cnt_q)) cnt_q <= cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  assign contention_err   = cont_q;
  assign sts_err          = sts_q;
  assign turnaround_err   = ta_q;
  assign parity_err       = perr_q;
  assign contention_count = cnt_q;

endmodule

// File: tb/tb_pci_bus_resolver.sv
// Bench for pci_bus_resolver: directed scenarios plus random traffic against a per-cycle model.
module tb_pci_bus_resolver;

  localparam int NA  = 2;
  localparam int AW  = 32;
  localparam int CBW = AW / 8;
  localparam int CW  = 6;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst, clr_err;
  logic [NA*AW-1:0]  ad_o;
  logic [NA-1:0]     ad_oe, cbe_oe, par_o, par_oe;
  logic [NA*CBW-1:0] cbe_o;
  logic [NA*6-1:0]   ctl_o, ctl_oe;
  logic [AW-1:0]     ad_bus;
  logic [CBW-1:0]    cbe_bus;
  logic              par_bus, ad_float, turnaround_err, parity_err;
  logic [5:0]        ctl_bus, sts_err;
  logic [3:0]        contention_err;
  logic [CW-1:0]     contention_count;

  always #5 clk = ~clk;

  pci_bus_resolver #(.NUM_AGENTS(NA), .AD_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .ad_o(ad_o), .ad_oe(ad_oe), .cbe_o(cbe_o), .cbe_oe(cbe_oe),
    .par_o(par_o), .par_oe(par_oe), .ctl_o(ctl_o), .ctl_oe(ctl_oe), .clr_err(clr_err),
    .ad_bus(ad_bus), .cbe_bus(cbe_bus), .par_bus(par_bus), .ctl_bus(ctl_bus),
    .ad_float(ad_float), .contention_err(contention_err), .sts_err(sts_err),
    .turnaround_err(turnaround_err), .parity_err(parity_err),
    .contention_count(contention_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [AW-1:0]  m_ad_keep;
  logic [CBW-1:0] m_cbe_keep;
  logic           m_par_keep, m_exp_par, m_exp_vld, m_ta, m_perr;
  logic [NA*6-1:0] m_prev_oe, m_prev_o;
  int             m_owner, m_cnt;
  logic [3:0]     m_cont;
  logic [5:0]     m_sts;
  // Expected combinational view of the current inputs
  logic [AW-1:0]  e_ad;
  logic [CBW-1:0] e_cbe;
  logic           e_par, e_float;
  logic [5:0]     e_ctl;
  int             n_ad, n_cbe, n_par, ad_drv;
  int             n_ctl [6];

  task automatic model_reset();
    m_ad_keep = '0; m_cbe_keep = '0; m_par_keep = 1'b0;
    m_prev_oe = '0; m_prev_o = '0; m_owner = -1;
    m_exp_par = 1'b0; m_exp_vld = 1'b0;
    m_cont = '0; m_sts = '0; m_ta = 1'b0; m_perr = 1'b0; m_cnt = 0;
  endtask

  task automatic model_comb();
    n_ad = 0; n_cbe = 0; n_par = 0; ad_drv = 0;
    e_ad = '1; e_cbe = '1; e_par = 1'b1; e_ctl = '1;
    for (int a = 0; a < NA; a++) begin
      if (ad_oe[a]) begin n_ad++; e_ad &= ad_o[a*AW +: AW]; ad_drv = a; end
      if (cbe_oe[a]) begin n_cbe++; e_cbe &= cbe_o[a*CBW +: CBW]; end
      if (par_oe[a]) begin n_par++; e_par &= par_o[a]; end
    end
    for (int b = 0; b < 6; b++) begin
      n_ctl[b] = 0;
      for (int a = 0; a < NA; a++)
        if (ctl_oe[a*6+b]) begin n_ctl[b]++; e_ctl[b] &= ctl_o[a*6+b]; end
    end
    if (n_ad == 0) e_ad = m_ad_keep;
    if (n_cbe == 0) e_cbe = m_cbe_keep;
    if (n_par == 0) e_par = m_par_keep;
    e_float = (n_ad == 0);
  endtask

  task automatic model_edge();
    logic [3:0] c;
    logic [5:0] s;
    logic t, p;
    if (rst) begin
      model_reset();
      return;
    end
    c = '0; s = '0;
    c[0] = (n_ad > 1); c[1] = (n_cbe > 1); c[2] = (n_par > 1);
    for (int b = 0; b < 6; b++) begin
      if (n_ctl[b] > 1) c[3] = 1'b1;
      for (int a = 0; a < NA; a++)
        if (m_prev_oe[a*6+b] && !m_prev_o[a*6+b] && !ctl_oe[a*6+b]) s[b] = 1'b1;
    end
    t = (m_owner >= 0) && (n_ad == 1) && (ad_drv != m_owner);
    p = m_exp_vld && (n_par == 1) && (e_par != m_exp_par);
    if (n_ad == 1) begin m_exp_par = ^{e_ad, e_cbe}; m_ad_keep = e_ad; m_owner = ad_drv; end
    else if (n_ad == 0) m_owner = -1;
    m_exp_vld = (n_ad == 1);
    if (n_cbe == 1) m_cbe_keep = e_cbe;
    if (n_par == 1) m_par_keep = e_par;
    m_prev_oe = ctl_oe; m_prev_o = ctl_o;
    if (clr_err) begin
      m_cont = '0; m_sts = '0; m_ta = 1'b0; m_perr = 1'b0; m_cnt = 0;
    end else begin
      m_cont |= c; m_sts |= s; m_ta |= t; m_perr |= p;
      if (c != 0 && m_cnt < CMAX) m_cnt++;
    end
  endtask

  // Inputs are set just after a negedge; compare outputs, clock once, compare state.
  task automatic cycle();
    #1;
    model_comb();
    check_eq("ad_bus", ad_bus, e_ad);
    check_eq("cbe_bus", cbe_bus, e_cbe);
    check_eq("par_bus", par_bus, e_par);
    check_eq("ctl_bus", ctl_bus, e_ctl);
    check_eq("ad_float", ad_float, e_float);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_eq("contention_err", contention_err, m_cont);
    check_eq("sts_err", sts_err, m_sts);
    check_eq("turnaround_err", turnaround_err, m_ta);
    check_eq("parity_err", parity_err, m_perr);
    check_eq("contention_count", contention_count, m_cnt);
  endtask

  task automatic set_idle();
    ad_o = '0; ad_oe = '0; cbe_o = '0; cbe_oe = '0; par_o = '0; par_oe = '0;
    ctl_o = '0; ctl_oe = '0; clr_err = 1'b0; rst = 1'b0;
  endtask

  task automatic clear_flags();
    set_idle(); clr_err = 1'b1; cycle();
    set_idle(); cycle();
  endtask

  initial begin
    set_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_ctl_pullup", ctl_bus, 6'h3F);
    check_eq("rst_ad_keeper", ad_bus, 32'h0);
    check_eq("rst_flags", {contention_err, sts_err, turnaround_err, parity_err}, 12'h0);
    check_eq("rst_count", contention_count, 0);
    @(negedge clk);

    // Keeper holds the last driven AD value once the bus floats.
    ad_o[31:0] = 32'hDEADBEEF; ad_oe = 2'b01; cycle();
    set_idle(); #1;
    check_eq("keeper_ad", ad_bus, 32'hDEADBEEF);
    check_eq("keeper_float", ad_float, 1'b1);
    cycle();
    check_eq("keeper_noerr", {contention_err, sts_err, turnaround_err, parity_err}, 12'h0);

    // AD contention resolves to AND and counts every cycle.
    ad_o = {32'h00FFFF00, 32'hFFFF0000}; ad_oe = 2'b11; #1;
    check_eq("cont_and", ad_bus, 32'h00FF0000);
    repeat (3) cycle();
    check_eq("cont_flag", contention_err, 4'b0001);
    check_eq("cont_count3", contention_count, 3);
    set_idle(); clr_err = 1'b1; cycle();
    check_eq("clr_flags", contention_err, 4'b0000);
    check_eq("clr_count", contention_count, 0);

    // s/t/s: releasing TRDY# straight from low is illegal, via a high cycle it is legal.
    set_idle(); ctl_oe[8] = 1'b1; ctl_o[8] = 1'b0; cycle();
    set_idle(); cycle();
    check_eq("sts_violation", sts_err, 6'b000100);
    clear_flags();
    ctl_oe[8] = 1'b1; ctl_o[8] = 1'b0; cycle();
    ctl_o[8] = 1'b1; cycle();
    set_idle(); cycle();
    check_eq("sts_legal", sts_err, 6'b000000);

    // Turnaround: back-to-back owners vs. one idle cycle between them.
    clear_flags();
    ad_oe = 2'b01; cycle();
    ad_oe = 2'b10; cycle();
    check_eq("ta_violation", turnaround_err, 1'b1);
    clear_flags();
    ad_oe = 2'b01; cycle();
    set_idle(); cycle();
    ad_oe = 2'b10; cycle();
    check_eq("ta_legal", turnaround_err, 1'b0);

    // Parity: AD=1, CBE=0 needs PAR=1 the following cycle.
    for (int k = 0; k < 2; k++) begin
      clear_flags();
      ad_o[31:0] = 32'h1; ad_oe = 2'b01; cbe_oe = 2'b01; cycle();
      set_idle(); par_oe = 2'b01; par_o[0] = k[0]; cycle();
      check_eq(k == 0 ? "par_bad" : "par_good", parity_err, k == 0 ? 1'b1 : 1'b0);
    end

    // Counter saturation, then reset in the middle of the burst.
    clear_flags();
    ad_o = {32'h12345678, 32'h87654321}; ad_oe = 2'b11;
    repeat (CMAX + 6) cycle();
    check_eq("cnt_saturate", contention_count, CMAX);
    rst = 1'b1; cycle();
    check_eq("rst_mid_count", contention_count, 0);
    check_eq("rst_mid_flags", {contention_err, sts_err, turnaround_err, parity_err}, 12'h0);
    set_idle(); #1;
    check_eq("rst_mid_pullup", ctl_bus, 6'h3F);
    cycle();

    // Random traffic with sparse enables so single-driver cycles dominate.
    for (int n = 0; n < 400; n++) begin
      ad_o  = {$urandom, $urandom};
      cbe_o = 8'($urandom);
      par_o = 2'($urandom);
      ctl_o = 12'($urandom);
      for (int a = 0; a < NA; a++) begin
        ad_oe[a]  = ($urandom_range(0, 2) == 0);
        cbe_oe[a] = ($urandom_range(0, 2) == 0);
        par_oe[a] = ($urandom_range(0, 2) == 0);
      end
      for (int j = 0; j < NA * 6; j++) ctl_oe[j] = ($urandom_range(0, 3) == 0);
      clr_err = ($urandom_range(0, 5) == 0);
      rst     = ($urandom_range(0, 63) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pci_bus_resolver.md
Name: pci_bus_resolver

Overview:
- Simulation-side PCI bus resolution block for the Verilator testbench; Verilator has no tristate nets, so this block stands in for them.
- Takes per-agent drive values and output-enables for N agents (device under test, host model, extra targets) and produces the resolved bus.
- Models pullups on control lines and a bus keeper on AD/CBE/PAR.
- Checks PCI electrical-protocol rules: driver contention, sustained-tristate (s/t/s) release, AD turnaround and parity, and reports sticky error flags and counts.

Parameters:
- NUM_AGENTS, 2, number of bus agents; legal 2..8.
- AD_WIDTH, 32, AD width; legal 32 or 64. CBE width is AD_WIDTH/8, a derived localparam.
- CNT_WIDTH, 16, width of the saturating contention counter.

Ports:
- clk  in  1  bus clock
- rst  in  1  synchronous, active-high reset
- ad_o  in  NUM_AGENTS*AD_WIDTH  per-agent AD drive value; agent i occupies bits [i*AD_WIDTH +: AD_WIDTH]
- ad_oe  in  NUM_AGENTS  per-agent AD output enable
- cbe_o  in  NUM_AGENTS*AD_WIDTH/8  per-agent C/BE# drive value
- cbe_oe  in  NUM_AGENTS  per-agent C/BE# output enable
- par_o  in  NUM_AGENTS  per-agent PAR drive value
- par_oe  in  NUM_AGENTS  per-agent PAR output enable
- ctl_o  in  NUM_AGENTS*6  per-agent s/t/s control values, bit order {perr,devsel,stop,trdy,irdy,frame}
- ctl_oe  in  NUM_AGENTS*6  per-agent control output enables, same bit order
- clr_err  in  1  synchronous clear of all sticky flags and the counter
- ad_bus  out  AD_WIDTH  resolved AD
- cbe_bus  out  AD_WIDTH/8  resolved C/BE#
- par_bus  out  1  resolved PAR
- ctl_bus  out  6  resolved control lines
- ad_float  out  1  high when no agent drives AD
- contention_err  out  4  sticky; bit0 AD, bit1 CBE, bit2 PAR, bit3 any ctl
- sts_err  out  6  sticky per control line; s/t/s released while low
- turnaround_err  out  1  sticky; AD owner change with no idle cycle
- parity_err  out  1  sticky; PAR mismatch
- contention_count  out  CNT_WIDTH  saturating count of cycles with any contention

Behaviour:
- Resolution is combinational, zero latency. Per signal group:
  - 0 drivers: control lines resolve to 1 (pullup). AD/CBE/PAR resolve to the keeper register value.
  - 1 driver: that agent's value.
  - More than 1 driver: bitwise AND of all enabled drivers' values. The group's contention bit is set on the next clk edge.
- Keeper registers: on each clk edge with exactly one driver, AD/CBE/PAR keepers load the resolved value; otherwise they hold. Reset value 0.
- ad_float is combinational: 1 when no ad_oe bit is set.
- s/t/s check, per agent and per control bit, using registered prev_oe and prev_o:
  - Violation when prev_oe=1, prev_o=0 and the current oe=0 (released without a one-cycle drive-high).
  - Sets the matching sts_err bit on the next edge.
  - Releasing after driving 1 is legal.
- Turnaround check: an ad_owner register holds the agent index plus a valid bit. Each edge:
  - exactly one AD driver → owner := that agent, valid := 1;
  - no driver → valid := 0.
  - Error when valid=1, exactly one driver this cycle, and that driver differs from the owner.
- Parity check:
  - Registered exp_par = XOR(ad_bus[31:0], cbe_bus[3:0]), captured only on cycles where exactly one AD driver is present.
  - Next cycle, if exp_par was captured and exactly one PAR driver is present, a par_bus mismatch sets parity_err.
  - Upper AD/CBE lanes (AD_WIDTH=64) are not parity-checked.
- Contention counter: +1 per cycle in which any group has more than 1 driver. Saturates at all-ones; no wrap.
- Sticky flags and the counter hold until rst or clr_err.
  - clr_err has priority over a same-cycle new error: the flag reads 0 after that edge.
  - Errors in the following cycle set flags again.
- Reset (synchronous, may arrive mid-transaction): on the edge with rst=1, all flags, counter, keepers, prev_oe/prev_o, ad_owner.valid and exp_par-valid go to 0.
  - Checks are suppressed in the cycle after reset because the history registers are 0.
  - Resolved outputs stay combinational during reset. Control lines read 1 when undriven.

Test Plan:
- Agent 0 drives ad_o=0xDEADBEEF with ad_oe=01 for 1 cycle, then ad_oe=00 → ad_bus=0xDEADBEEF in both cycles; ad_float=1 in the second cycle; no errors.
- ad_oe=11, agent0=0xFFFF0000, agent1=0x00FFFF00 for 3 cycles → ad_bus=0x00FF0000; contention_err[0]=1; contention_count=3; then clr_err → all 0.
- Agent 1 drives trdy=0, next cycle oe=0 → sts_err[2]=1. Repeat with trdy=0, then trdy=1, then oe=0 → sts_err stays 0.
- Agent 0 drives AD at cycle n, agent 1 at n+1 → turnaround_err=1. Insert one idle cycle between them → turnaround_err=0.
- Cycle n: ad=0x00000001, cbe=0x0, one AD driver. Cycle n+1: par=0 → parity_err=1. With par=1 instead → 0.
- Force contention for 2^CNT_WIDTH+5 cycles → contention_count saturates at all-ones. Assert rst mid-burst → everything 0 on the next edge; ctl_bus=0x3F with no drivers.
